inst_fetch_unit: RTL

- Initiator side of the instruction-memory interface.
- Owns the program counter and drives `Pc` into the synchronous-read instruction memory. The memory returns `InstReg` one clock after it samples `Pc`.
- Pairs each returned word with the address that fetched it and hands the pair to decode through a valid/ready handshake.
- Handles downstream stalls with a one-entry hold buffer, and branch redirects by flushing in-flight fetches.

---
 rtl/inst_fetch_unit.sv | 95 +++++++++
 1 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch: owns the PC, tags each synchronous-read memory word with its
// address, and presents it to decode over valid/ready with a one-entry skid buffer.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic [31:0] Pc,
    input  logic [31:0] InstReg,
    input  logic        Ready,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic        Valid,
    output logic [31:0] InstOut,
    output logic [31:0] PcOut,
    output logic [31:0] PcPlus4,
    output logic        BadPc,
    output logic        AlignErr
);

    localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS);

    logic [31:0] pc_q, pc_d;
    logic [31:0] resp_pc_q, resp_pc_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] hold_inst_q, hold_inst_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic        hold_valid_q, hold_valid_d;
    logic        align_err_q, align_err_d;

    always_comb begin
        pc_d         = pc_q;
        resp_pc_d    = resp_pc_q;
        resp_valid_d = resp_valid_q;
        hold_inst_d  = hold_inst_q;
        hold_pc_d    = hold_pc_q;
        hold_valid_d = hold_valid_q;
        align_err_d  = 1'b0;

        if (BranchTaken) begin
            // The read issued at this edge belongs to the old path and is dropped.
            pc_d         = {BranchTarget[31:2], 2'b00};
            resp_valid_d = 1'b0;
            hold_valid_d = 1'b0;
            align_err_d  = |BranchTarget[1:0];
        end else if (hold_valid_q && !Ready) begin
            pc_d = pc_q;
        end else if (hold_valid_q) begin
            hold_valid_d = 1'b0;
            resp_pc_d    = pc_q;
            resp_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
        end else if (resp_valid_q && !Ready) begin
            // Pc stays put so the word being read now is fetched again on release.
            hold_inst_d  = InstReg;
            hold_pc_d    = resp_pc_q;
            hold_valid_d = 1'b1;
            resp_valid_d = 1'b0;
        end else begin
            resp_pc_d    = pc_q;
            resp_valid_d = 1'b1;
            pc_d         = pc_q + 32'd4;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q         <= RESET_PC;
            resp_pc_q    <= 32'd0;
            resp_valid_q <= 1'b0;
            hold_inst_q  <= 32'd0;
            hold_pc_q    <= 32'd0;
            hold_valid_q <= 1'b0;
            align_err_q  <= 1'b0;
        end else begin
            pc_q         <= pc_d;
            resp_pc_q    <= resp_pc_d;
            resp_valid_q <= resp_valid_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc_q    <= hold_pc_d;
            hold_valid_q <= hold_valid_d;
            align_err_q  <= align_err_d;
        end
    end

    assign Pc       = pc_q;
    assign Valid    = hold_valid_q | resp_valid_q;
    assign InstOut  = hold_valid_q ? hold_inst_q : InstReg;
    assign PcOut    = hold_valid_q ? hold_pc_q : resp_pc_q;
    assign PcPlus4  = PcOut + 32'd4;
    assign BadPc    = Valid && ({2'b00, PcOut[31:2]} >= IMEM_LIMIT);
    assign AlignErr = align_err_q;

endmodule
